fetch_queue_unit: RTL and testbench
===================================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised successor to the C16 single-instruction fetch stage. Issues sequential PCs to a
//  fixed-latency synchronous instruction RAM, buffers returned words with their PCs in a DEPTH-entry
//  queue, and hands them to decode over valid/ready. Supports decode back-pressure and
//  redirect-with-flush from execute (branch, call).
// PARAMETERS
//  XLEN      16      instruction and PC width
//  DEPTH     4       instruction queue entries; >=2, power of two
//  MEM_LAT   1       RAM read latency in cycles, address to data; >=1
//  RESET_PC  16'h0   first PC fetched after reset
// PORTS
//  clk          in   1     rising-edge clock
//  CPU_RESET_n  in   1     asynchronous active-low reset
//  redir_en     in   1     execute redirect strobe (pc_write_enable)
//  redir_pc     in   XLEN  redirect target
//  mem_req      out  1     read request this cycle
//  mem_addr     out  XLEN  read address; combinational, same cycle as mem_req
//  mem_rdata    in   XLEN  read data, valid exactly MEM_LAT cycles after the matching mem_req
//  inst_valid   out  1     queue head valid
//  inst_ready   in   1     decode accepts head
//  inst_data    out  XLEN  head instruction
//  inst_pc      out  XLEN  head PC
// BEHAVIOUR
//  - Reset, async assert: fetch_pc=RESET_PC; queue empty; in-flight pipe cleared.
//    Outputs: inst_valid=0, inst_data=0, inst_pc=0, mem_req=0, all counters 0. First mem_req in the
//    first clk after CPU_RESET_n deasserts.
//  - Credit rule: issue allowed iff occupancy + inflight < DEPTH, so a queue overflow is impossible.
//    occupancy uses $clog2(DEPTH+1) bits.
//  - Issue, no redirect: mem_req=credit_ok, mem_addr=fetch_pc. On issue, fetch_pc<=fetch_pc+1, modulo
//    2^XLEN, so 16'hFFFF wraps to 0.
//  - Redirect cycle (redir_en=1), precedence over everything else:
//    - queue flushed, all in-flight valid bits cleared, responses due this cycle are dropped.
//    - inst_valid forced 0 in the same cycle; any concurrent pop is ignored.
//    - mem_req=1, mem_addr=redir_pc, fetch_pc<=redir_pc+1.
//  - In-flight tracking: MEM_LAT-deep shift register of {valid, pc}. A response enters the queue at
//    the tail in the cycle it emerges with valid=1.
//  - Pop: inst_valid&&inst_ready, no redirect -> head advances. Push and pop in the same cycle keep
//    occupancy unchanged.
//  - Empty queue: inst_valid=0, no combinational bypass from mem_rdata. Minimum latency from issue
//    to inst_valid is MEM_LAT+1 cycles.
//  - inst_data and inst_pc hold stable while inst_valid&&!inst_ready.
//  - Pointers wrap modulo DEPTH.
// CONFIGURATION
//  FETCH_STATS_EN defined:
//    - adds outputs stat_stall (32b) and stat_redir (32b), both saturating, reset 0.
//    - stat_stall counts cycles with inst_valid&&!inst_ready; stat_redir counts redir_en cycles.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - c16_pkg: XLEN, pc_t, instr_t, fetch_entry_t {pc_t pc; instr_t instr;}, RESET_PC default.
//  - Sub-module fetch_fifo:
//    - DEPTH-entry circular buffer of fetch_entry_t with push, pop, flush, count, full and empty.
//    - flush has priority over push and pop.
//  - Top level holds fetch_pc, the credit check and the in-flight shift register.
// TESTING
//  - Reset, MEM_LAT=1, ready=1:
//    - mem_addr 0,1,2,... on consecutive cycles.
//    - inst_pc=0 at cycle 2 after release, then one instruction per cycle.
//  - Hold inst_ready=0 for 10 cycles: issues stop after 4 outstanding (DEPTH=4); head is stable at
//    pc 0. Release -> pcs 0..3, then 4,... with no gap or duplicate.
//  - redir_en with redir_pc=16'h0040 while 3 are queued and 1 in flight: next inst_pc=16'h0040. Stale
//    words are never presented.
//  - Back-to-back redir_en to 16'h10 then 16'h20 on consecutive cycles, MEM_LAT=3: only the 16'h20
//    stream appears.
//  - fetch_pc=16'hFFFE: presented pcs are FFFE, FFFF, 0000.
//  - Assert CPU_RESET_n low mid-stream, asynchronously: inst_valid and mem_req drop before the next
//    clk edge. Restart from RESET_PC. With FETCH_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/c16_pkg.sv
// Shared types for the C16 fetch path: machine width, PC/instruction types and the queue entry.
package c16_pkg;
  localparam int XLEN = 16;

  typedef logic [XLEN-1:0] pc_t;
  typedef logic [XLEN-1:0] instr_t;

  typedef struct packed {
    pc_t    pc;
    instr_t instr;
  } fetch_entry_t;

  localparam pc_t RESET_PC_DEFAULT = '0;
endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue of fetch_entry_t with push, pop and flush; flush wins over both.
module fetch_fifo
  import c16_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end
endmodule

// File: rtl/fetch_queue_unit.sv
// Sequential-PC fetch unit with credit-limited issue, in-flight tracking and a decode queue.
// Optional FETCH_STATS_EN adds saturating stall/redirect counters.
module fetch_queue_unit
  import c16_pkg::*;
#(
  parameter int  DEPTH    = 4,
  parameter int  MEM_LAT  = 1,
  parameter pc_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            CPU_RESET_n,
  input  logic            redir_en,
  input  logic [XLEN-1:0] redir_pc,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     stat_stall,
  output logic [31:0]     stat_redir
`endif
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  pc_t              fetch_pc;
  logic [MEM_LAT-1:0] vld_p;
  pc_t              pc_p [MEM_LAT];
  int               inflight;
  logic             credit_ok;
  logic             issue;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + (vld_p[i] ? 1 : 0);
  end

  // Everything already queued or still in the RAM pipe holds a slot, so a push never overflows.
  assign credit_ok  = !full && ((int'(count) + inflight) < DEPTH);
  assign issue      = CPU_RESET_n && (redir_en || credit_ok);
  assign mem_req    = issue;
  assign mem_addr   = redir_en ? redir_pc : fetch_pc;

  assign push       = vld_p[MEM_LAT-1] && !redir_en;
  assign push_entry = '{pc: pc_p[MEM_LAT-1], instr: mem_rdata};
  assign inst_valid = !empty && !redir_en;
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = inst_valid ? head.instr : '0;
  assign inst_pc    = inst_valid ? head.pc : '0;

  // In-flight stage boundary: request enters stage 0, response pairs with mem_rdata at the last stage.
  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      fetch_pc <= RESET_PC;
      vld_p    <= '0;
    end else begin
      if (redir_en)   fetch_pc <= redir_pc + pc_t'(1);
      else if (issue) fetch_pc <= fetch_pc + pc_t'(1);
      vld_p[0] <= issue;
      for (int i = 1; i < MEM_LAT; i++) vld_p[i] <= redir_en ? 1'b0 : vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pc_p[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) pc_p[i] <= pc_p[i-1];
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (CPU_RESET_n),
    .flush      (redir_en),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

`ifdef FETCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      stat_stall <= '0;
      stat_redir <= '0;
    end else begin
      if (inst_valid && !inst_ready) stat_stall <= sat_inc(stat_stall);
      if (redir_en)                  stat_redir <= sat_inc(stat_redir);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: MEM_LAT=1 and MEM_LAT=3 instances share stimulus; a stream model
// checks every cycle, and directed literals pin latency, credit, redirect and wrap behaviour.
module tb_fetch_queue_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redir_en;
  logic [15:0] redir_pc;
  logic        inst_ready;

  logic        mreq1, mreq3, iv1, iv3;
  logic [15:0] maddr1, maddr3, rdata1, rdata3, idata1, idata3, ipc1, ipc3;
`ifdef FETCH_STATS_EN
  logic [31:0] stall1, stall3, rcnt1, rcnt3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] ram_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Synchronous RAM models with 1 and 3 cycle read latency.
  logic [15:0] ap1;
  logic [15:0] ap3 [3];
  always @(posedge clk) begin
    ap1    <= maddr1;
    ap3[0] <= maddr3;
    ap3[1] <= ap3[0];
    ap3[2] <= ap3[1];
  end
  assign rdata1 = ram_word(ap1);
  assign rdata3 = ram_word(ap3[2]);

  fetch_queue_unit #(.DEPTH(4), .MEM_LAT(1), .RESET_PC(16'h0000)) dut1 (
    .clk(clk), .CPU_RESET_n(rst_n), .redir_en(redir_en), .redir_pc(redir_pc),
    .mem_req(mreq1), .mem_addr(maddr1), .mem_rdata(rdata1),
    .inst_valid(iv1), .inst_ready(inst_ready), .inst_data(idata1), .inst_pc(ipc1)
`ifdef FETCH_STATS_EN
    , .stat_stall(stall1), .stat_redir(rcnt1)
`endif
  );

  fetch_queue_unit #(.DEPTH(4), .MEM_LAT(3), .RESET_PC(16'h0000)) dut3 (
    .clk(clk), .CPU_RESET_n(rst_n), .redir_en(redir_en), .redir_pc(redir_pc),
    .mem_req(mreq3), .mem_addr(maddr3), .mem_rdata(rdata3),
    .inst_valid(iv3), .inst_ready(inst_ready), .inst_data(idata3), .inst_pc(ipc3)
`ifdef FETCH_STATS_EN
    , .stat_stall(stall3), .stat_redir(rcnt3)
`endif
  );

  task automatic cmp(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lat%0d got=%h want=%h t=%0t", name, (k == 0) ? 1 : 3, act, exp, $time);
    end
  endtask

  // Stream model: the presented head is always the next PC of the current stream, its data is
  // the RAM word at that PC, requests walk the stream in order, and outstanding work <= DEPTH.
  logic [15:0] exp_pc  [2];
  logic [15:0] exp_iss [2];
  int          outst   [2];
  int          req_cnt [2];
  logic        held    [2];
  logic [15:0] held_pc [2];
  int          stall_m [2];
  int          redir_m [2];

  task automatic chk(input int k, input logic mreq, input logic [15:0] maddr, input logic iv,
                     input logic [15:0] idata, input logic [15:0] ipc);
    if (!rst_n) begin
      cmp("reset_valid", k, {31'd0, iv}, 32'd0);
      cmp("reset_req", k, {31'd0, mreq}, 32'd0);
      cmp("reset_pc", k, {16'd0, ipc}, 32'd0);
      cmp("reset_data", k, {16'd0, idata}, 32'd0);
      exp_pc[k] = 16'h0000; exp_iss[k] = 16'h0000;
      outst[k] = 0; req_cnt[k] = 0; held[k] = 1'b0;
      return;
    end
    if (mreq) req_cnt[k]++;
    if (redir_en) begin
      cmp("redir_valid", k, {31'd0, iv}, 32'd0);
      cmp("redir_req", k, {31'd0, mreq}, 32'd1);
      cmp("redir_addr", k, {16'd0, maddr}, {16'd0, redir_pc});
      exp_pc[k]  = redir_pc;
      exp_iss[k] = redir_pc + 16'd1;
      outst[k]   = 1;
      held[k]    = 1'b0;
      return;
    end
    if (mreq) begin
      cmp("issue_addr", k, {16'd0, maddr}, {16'd0, exp_iss[k]});
      exp_iss[k] = exp_iss[k] + 16'd1;
      outst[k]++;
    end
    if (held[k]) begin
      cmp("hold_valid", k, {31'd0, iv}, 32'd1);
      cmp("hold_pc", k, {16'd0, ipc}, {16'd0, held_pc[k]});
    end
    if (iv) begin
      cmp("head_pc", k, {16'd0, ipc}, {16'd0, exp_pc[k]});
      cmp("head_data", k, {16'd0, idata}, {16'd0, ram_word(ipc)});
      if (inst_ready) begin
        exp_pc[k] = exp_pc[k] + 16'd1;
        outst[k]--;
        held[k] = 1'b0;
      end else begin
        held[k] = 1'b1;
        held_pc[k] = ipc;
      end
    end else begin
      held[k] = 1'b0;
    end
    cmp("credit", k, {31'd0, (outst[k] <= 4)}, 32'd1);
  endtask

  always @(negedge clk) begin
    chk(0, mreq1, maddr1, iv1, idata1, ipc1);
    chk(1, mreq3, maddr3, iv3, idata3, ipc3);
`ifdef FETCH_STATS_EN
    if (!rst_n) begin
      stall_m[0] = 0; stall_m[1] = 0; redir_m[0] = 0; redir_m[1] = 0;
    end
    cmp("stat_stall", 0, stall1, stall_m[0]);
    cmp("stat_stall", 1, stall3, stall_m[1]);
    cmp("stat_redir", 0, rcnt1, redir_m[0]);
    cmp("stat_redir", 1, rcnt3, redir_m[1]);
    if (rst_n) begin
      if (iv1 && !inst_ready) stall_m[0]++;
      if (iv3 && !inst_ready) stall_m[1]++;
      if (redir_en) begin redir_m[0]++; redir_m[1]++; end
    end
`endif
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int k, input int budget);
    int n = 0;
    while (!((k == 0) ? iv1 : iv3) && n < budget) begin
      step(1);
      n++;
    end
    cmp("wait_valid", k, {31'd0, ((k == 0) ? iv1 : iv3)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat;
    rst_n = 1'b0; redir_en = 1'b0; redir_pc = 16'h0000; inst_ready = 1'b1;
    step(3);
    cmp("lit_rst_valid", 0, {31'd0, iv1}, 32'd0);
    cmp("lit_rst_req", 1, {31'd0, mreq3}, 32'd0);

    // Release: sequential addresses, first instruction two cycles later (four for MEM_LAT=3).
    rst_n = 1'b1; #1;
    cmp("lit_first_req", 0, {31'd0, mreq1}, 32'd1);
    cmp("lit_addr0", 0, {16'd0, maddr1}, 32'h0);
    step(1); cmp("lit_addr1", 0, {16'd0, maddr1}, 32'h1);
    step(1); cmp("lit_addr2", 0, {16'd0, maddr1}, 32'h2);
    cmp("lit_valid_c2", 0, {31'd0, iv1}, 32'd1);
    cmp("lit_pc_c2", 0, {16'd0, ipc1}, 32'h0);
    cmp("lit_ml3_idle", 1, {31'd0, iv3}, 32'd0);
    step(1); cmp("lit_pc_c3", 0, {16'd0, ipc1}, 32'h1);
    cmp("lit_ml3_idle3", 1, {31'd0, iv3}, 32'd0);
    step(1); cmp("lit_ml3_valid", 1, {31'd0, iv3}, 32'd1);
    cmp("lit_ml3_pc0", 1, {16'd0, ipc3}, 32'h0);
    step(8);

    // Back-pressure from reset: four requests then stall with head at pc 0.
    rst_n = 1'b0; inst_ready = 1'b0; step(1);
    rst_n = 1'b1; step(10);
    cmp("lit_credit_stop", 0, req_cnt[0], 32'd4);
    cmp("lit_credit_stop", 1, req_cnt[1], 32'd4);
    cmp("lit_hold_pc", 0, {16'd0, ipc1}, 32'h0);
    cmp("lit_hold_pc", 1, {16'd0, ipc3}, 32'h0);
    inst_ready = 1'b1; step(12);

    // Redirect with three queued and one in flight.
    rst_n = 1'b0; inst_ready = 1'b0; step(1);
    rst_n = 1'b1; step(4);
    redir_en = 1'b1; redir_pc = 16'h0040; step(1);
    redir_en = 1'b0; inst_ready = 1'b1;
    wait_valid(0, 8); cmp("lit_redir_pc", 0, {16'd0, ipc1}, 32'h0040);
    wait_valid(1, 8); cmp("lit_redir_pc", 1, {16'd0, ipc3}, 32'h0040);
    step(5);

    // Back-to-back redirects: only the second stream may appear.
    redir_en = 1'b1; redir_pc = 16'h0010; step(1);
    redir_pc = 16'h0020; step(1);
    redir_en = 1'b0;
    wait_valid(0, 8);  cmp("lit_b2b_pc", 0, {16'd0, ipc1}, 32'h0020);
    wait_valid(1, 12); cmp("lit_b2b_pc", 1, {16'd0, ipc3}, 32'h0020);
    step(5);

    // PC wrap at the top of the address space.
    redir_en = 1'b1; redir_pc = 16'hFFFE; step(1);
    redir_en = 1'b0;
    wait_valid(0, 8); cmp("lit_wrap0", 0, {16'd0, ipc1}, 32'hFFFE);
    step(1); cmp("lit_wrap1", 0, {16'd0, ipc1}, 32'hFFFF);
    step(1); cmp("lit_wrap2", 0, {16'd0, ipc1}, 32'h0000);

    // Irregular decode readiness.
    pat = 32'hB3C5_7A19;
    for (int i = 0; i < 32; i++) begin
      inst_ready = pat[i];
      step(1);
    end
    inst_ready = 1'b1; step(4);

    // Asynchronous reset mid-stream: outputs drop before the next edge.
    #2; rst_n = 1'b0; #1;
    cmp("lit_async_valid", 0, {31'd0, iv1}, 32'd0);
    cmp("lit_async_valid", 1, {31'd0, iv3}, 32'd0);
    cmp("lit_async_req", 0, {31'd0, mreq1}, 32'd0);
    cmp("lit_async_req", 1, {31'd0, mreq3}, 32'd0);
`ifdef FETCH_STATS_EN
    cmp("lit_async_stall", 0, stall1, 32'd0);
    cmp("lit_async_redir", 1, rcnt3, 32'd0);
`endif
    step(1); rst_n = 1'b1;
    wait_valid(0, 6); cmp("lit_restart_pc", 0, {16'd0, ipc1}, 32'h0);
    wait_valid(1, 8); cmp("lit_restart_pc", 1, {16'd0, ipc3}, 32'h0);
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
